// File: rtl/serpent_encrypt_iter.sv
// Iterative Serpent encryptor, bitslice mode, one round per clock.
// Captures the 33 streamed subkeys locally and encrypts 128-bit blocks.
//
// sboxes ports:
//   idx  : S-box number 0..7
//   din  : four input words, word0 = [31:0]
//   dout : four output words after bitwise S-box application
//
// serpent_encrypt_iter ports:
//   i_clk, i_rstn              : clock, async active-low reset
//   i_subkey, i_subkey_addr    : streamed subkey and its index (0..32)
//   i_subkey_valid             : subkey set complete and stable (level)
//   i_start, i_plaintext       : encrypt request and its block
//   o_ciphertext, o_valid      : result and its one-cycle valid pulse
//   o_busy                     : operation in progress

module sboxes (
    input  logic [2:0]   idx,
    input  logic [127:0] din,
    output logic [127:0] dout
);
    // Each table holds 16 nibble entries, entry 0 in bits [3:0].
    logic [63:0] tbl;
    logic [3:0]  nib;
    logic [3:0]  res;

    always_comb begin
        unique case (idx)
            3'd0: tbl = 64'hC90724DEB56A1F83;
            3'd1: tbl = 64'h43D68EB1A50972CF;
            3'd2: tbl = 64'h25B04E1DFAC39768;
            3'd3: tbl = 64'hE57A421D369C8BF0;
            3'd4: tbl = 64'hD7E9A4526B0C38F1;
            3'd5: tbl = 64'h176D8E30C9A4B25F;
            3'd6: tbl = 64'h0A3DF19EB6485C27;
            3'd7: tbl = 64'h6539AC47B28E0FD1;
            default: tbl = '0;
        endcase
    end

    // Bit j of every word forms one 4-bit S-box input, word0 as LSB.
    always_comb begin
        dout = '0;
        nib  = '0;
        res  = '0;
        for (int j = 0; j < 32; j++) begin
            nib = {din[96+j], din[64+j], din[32+j], din[j]};
            res = tbl[{nib, 2'b00} +: 4];
            dout[j]    = res[0];
            dout[32+j] = res[1];
            dout[64+j] = res[2];
            dout[96+j] = res[3];
        end
    end
endmodule

module serpent_encrypt_iter (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic [127:0] i_subkey,
    input  logic [5:0]   i_subkey_addr,
    input  logic         i_subkey_valid,
    input  logic         i_start,
    input  logic [127:0] i_plaintext,
    output logic [127:0] o_ciphertext,
    output logic         o_valid,
    output logic         o_busy
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t       state;
    logic [4:0]   round;
    logic [127:0] data;
    logic [127:0] store [0:32];
    logic [127:0] rkey;
    logic [127:0] mix;
    logic [127:0] sout;
    logic [127:0] lt_out;
    logic         keys_ready;

    function automatic logic [127:0] lt(input logic [127:0] x);
        logic [31:0] x0, x1, x2, x3;
        x0 = x[31:0];
        x1 = x[63:32];
        x2 = x[95:64];
        x3 = x[127:96];
        x0 = {x0[18:0], x0[31:19]};
        x2 = {x2[28:0], x2[31:29]};
        x1 = x1 ^ x0 ^ x2;
        x3 = x3 ^ x2 ^ (x0 << 3);
        x1 = {x1[30:0], x1[31]};
        x3 = {x3[24:0], x3[31:25]};
        x0 = x0 ^ x1 ^ x3;
        x2 = x2 ^ x3 ^ (x1 << 7);
        x0 = {x0[26:0], x0[31:27]};
        x2 = {x2[9:0], x2[31:10]};
        return {x3, x2, x1, x0};
    endfunction

    assign keys_ready = i_subkey_valid;
    assign rkey       = store[{1'b0, round}];
    assign mix        = data ^ rkey;
    assign lt_out     = lt(sout);

    sboxes u_sbox (
        .idx  (round[2:0]),
        .din  (mix),
        .dout (sout)
    );

    // Capture is independent of the FSM; the scheduler parks on 32.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < 33; k++) store[k] <= '0;
        end else if (i_subkey_addr <= 6'd32) begin
            store[i_subkey_addr] <= i_subkey;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= IDLE;
            round        <= '0;
            data         <= '0;
            o_ciphertext <= '0;
            o_valid      <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_start && keys_ready) begin
                        data   <= i_plaintext;
                        round  <= '0;
                        o_busy <= 1'b1;
                        state  <= ROUND;
                    end
                end
                ROUND: begin
                    // A new schedule invalidates the keys: abort silently.
                    if (!keys_ready) begin
                        round  <= '0;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else if (round == 5'd31) begin
                        o_ciphertext <= sout ^ store[32];
                        o_valid      <= 1'b1;
                        state        <= DONE;
                    end else begin
                        data  <= lt_out;
                        round <= round + 5'd1;
                    end
                end
                DONE: begin
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    round   <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serpent_encrypt_iter.sv
// Directed bench for serpent_encrypt_iter.
// Expected results come from an in-bench bitslice Serpent model.
module tb_serpent_encrypt_iter;
    logic         i_clk;
    logic         i_rstn;
    logic [127:0] i_subkey;
    logic [5:0]   i_subkey_addr;
    logic         i_subkey_valid;
    logic         i_start;
    logic [127:0] i_plaintext;
    logic [127:0] o_ciphertext;
    logic         o_valid;
    logic         o_busy;

    int checks;
    int failures;

    logic [127:0] keys [0:32];

    int sb [8][16] = '{
        '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
        '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
        '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
        '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
        '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
        '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
        '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
        '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
    };

    serpent_encrypt_iter dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_subkey       (i_subkey),
        .i_subkey_addr  (i_subkey_addr),
        .i_subkey_valid (i_subkey_valid),
        .i_start        (i_start),
        .i_plaintext    (i_plaintext),
        .o_ciphertext   (o_ciphertext),
        .o_valid        (o_valid),
        .o_busy         (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] rol(input logic [31:0] w, input int n);
        return (w << n) | (w >> (32 - n));
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] pt);
        logic [31:0] w [4];
        logic [127:0] x;
        int n;
        int v;
        x = pt;
        for (int r = 0; r < 32; r++) begin
            x = x ^ keys[r];
            for (int i = 0; i < 4; i++) w[i] = 32'd0;
            for (int j = 0; j < 32; j++) begin
                n = 8 * int'(x[96+j]) + 4 * int'(x[64+j])
                  + 2 * int'(x[32+j]) + int'(x[j]);
                v = sb[r % 8][n];
                for (int i = 0; i < 4; i++) w[i][j] = v[i];
            end
            if (r < 31) begin
                w[0] = rol(w[0], 13);
                w[2] = rol(w[2], 3);
                w[1] = w[1] ^ w[0] ^ w[2];
                w[3] = w[3] ^ w[2] ^ (w[0] << 3);
                w[1] = rol(w[1], 1);
                w[3] = rol(w[3], 7);
                w[0] = w[0] ^ w[1] ^ w[3];
                w[2] = w[2] ^ w[3] ^ (w[1] << 7);
                w[0] = rol(w[0], 5);
                w[2] = rol(w[2], 22);
            end
            x = {w[3], w[2], w[1], w[0]};
        end
        return x ^ keys[32];
    endfunction

    task automatic load_keys();
        for (int k = 0; k < 33; k++) begin
            i_subkey_addr = 6'(k);
            i_subkey      = keys[k];
            tick();
        end
        i_subkey_addr = 6'd63;
        i_subkey      = '1;
        tick();
    endtask

    // Accept a start, then count edges until o_valid.
    task automatic run_enc(input logic [127:0] pt, input int perturb_at,
                           output int lat, output int busy_cnt);
        i_start     = 1'b1;
        i_plaintext = pt;
        tick();
        i_start     = 1'b0;
        i_plaintext = '0;
        lat         = 0;
        busy_cnt    = o_busy ? 1 : 0;
        for (int n = 1; n <= 100; n++) begin
            if (n == perturb_at) begin
                i_start     = 1'b1;
                i_plaintext = ~pt;
            end
            tick();
            i_start = 1'b0;
            if (o_busy) busy_cnt++;
            if (o_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    logic [127:0] exp_ct;
    logic [127:0] prev_ct;
    logic [127:0] pt2;
    int lat;
    int bcnt;
    int lat2;
    int seen;

    initial begin
        checks         = 0;
        failures       = 0;
        i_rstn         = 1'b0;
        i_subkey       = '1;
        i_subkey_addr  = 6'd63;
        i_subkey_valid = 1'b1;
        i_start        = 1'b0;
        i_plaintext    = '0;
        for (int k = 0; k < 33; k++) keys[k] = '0;

        #2;
        chk("rst_valid", 128'(o_valid), 128'd0);
        chk("rst_busy", 128'(o_busy), 128'd0);
        chk("rst_ct", o_ciphertext, 128'd0);
        #20;
        i_rstn = 1'b1;
        tick();
        tick();

        // Zero store after reset; addr 63 with all-ones must not land.
        exp_ct = model_enc(128'd0);
        run_enc(128'd0, 0, lat, bcnt);
        chk("zero_key_ct", o_ciphertext, exp_ct);
        chk("zero_key_lat", 128'(lat), 128'd32);
        chk("zero_key_busy", 128'(bcnt), 128'd33);
        prev_ct = o_ciphertext;
        tick();
        chk("valid_pulse", 128'(o_valid), 128'd0);
        chk("busy_fall", 128'(o_busy), 128'd0);
        chk("ct_hold", o_ciphertext, prev_ct);

        // Capture {4{k}} at each address.
        i_subkey_valid = 1'b0;
        for (int k = 0; k < 33; k++) keys[k] = {4{32'(k)}};
        load_keys();
        tick();
        i_subkey_valid = 1'b1;
        exp_ct = model_enc(128'd0);
        run_enc(128'd0, 0, lat, bcnt);
        chk("cap_ct", o_ciphertext, exp_ct);
        chk("cap_lat", 128'(lat), 128'd32);
        tick();

        // Start gated by keys not ready.
        i_subkey_valid = 1'b0;
        i_start        = 1'b1;
        i_plaintext    = 128'h5;
        tick();
        i_start = 1'b0;
        seen    = 0;
        for (int n = 0; n < 40; n++) begin
            if (o_busy || o_valid) seen++;
            tick();
        end
        chk("gate_idle", 128'(seen), 128'd0);
        i_subkey_valid = 1'b1;
        tick();

        // Random-ish keys; start re-pulsed at round 10 is ignored.
        for (int k = 0; k < 33; k++)
            keys[k] = {$urandom, $urandom, $urandom, $urandom};
        load_keys();
        pt2    = 128'hDEADBEEF_00000001_CAFEF00D_80000000;
        exp_ct = model_enc(pt2);
        run_enc(pt2, 11, lat, bcnt);
        chk("perturb_ct", o_ciphertext, exp_ct);
        chk("perturb_lat", 128'(lat), 128'd32);
        prev_ct = o_ciphertext;
        tick();

        // Abort at round 20.
        i_start     = 1'b1;
        i_plaintext = 128'h1234;
        tick();
        i_start = 1'b0;
        for (int n = 0; n < 20; n++) tick();
        chk("abort_busy_pre", 128'(o_busy), 128'd1);
        i_subkey_valid = 1'b0;
        tick();
        chk("abort_busy", 128'(o_busy), 128'd0);
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            if (o_valid) seen++;
            tick();
        end
        chk("abort_novalid", 128'(seen), 128'd0);
        chk("abort_ct_hold", o_ciphertext, prev_ct);
        i_subkey_valid = 1'b1;
        tick();

        // Back-to-back: second start on the first IDLE cycle.
        exp_ct = model_enc(128'd0);
        run_enc(128'd0, 0, lat, bcnt);
        chk("b2b_ct1", o_ciphertext, exp_ct);
        chk("b2b_lat1", 128'(lat), 128'd32);
        tick();
        chk("b2b_idle", 128'(o_busy), 128'd0);
        pt2    = 128'h0123456789ABCDEF0011223344556677;
        exp_ct = model_enc(pt2);
        run_enc(pt2, 0, lat2, bcnt);
        chk("b2b_ct2", o_ciphertext, exp_ct);
        chk("b2b_gap", 128'(lat + 2 + lat2), 128'd66);
        tick();

        // Async reset mid-round clears everything, store included.
        i_start     = 1'b1;
        i_plaintext = 128'hFFFF;
        tick();
        i_start = 1'b0;
        for (int n = 0; n < 5; n++) tick();
        i_rstn = 1'b0;
        #1;
        chk("midrst_valid", 128'(o_valid), 128'd0);
        chk("midrst_busy", 128'(o_busy), 128'd0);
        chk("midrst_ct", o_ciphertext, 128'd0);
        tick();
        i_rstn = 1'b1;
        tick();
        for (int k = 0; k < 33; k++) keys[k] = '0;
        pt2    = 128'h0000_0000_0000_0000_0000_0000_0000_00A5;
        exp_ct = model_enc(pt2);
        run_enc(pt2, 0, lat, bcnt);
        chk("midrst_store", o_ciphertext, exp_ct);
        chk("midrst_lat", 128'(lat), 128'd32);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
